// File: rtl/vec_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vec_issue_ctrl_pkg
// Shared definitions for the vector issue controller:
//   - XLEN and the unit-stride memory-op encoding
//   - RVV major opcodes and OP-V func3 groups
//   - issue FSM state encoding and instruction class
//   - decode select bundle handed to vec_decode
//   - classify_inst(): opcode/func3 -> instruction class
// -----------------------------------------------------------------------------
package vec_issue_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [1:0]  MOP_UNIT = 2'b00;

    typedef enum logic [6:0] {
        OP_VEC      = 7'h57,
        OP_LOAD_FP  = 7'h07,
        OP_STORE_FP = 7'h27
    } v_opcode_e;

    typedef enum logic [2:0] {
        F3_OPIVV = 3'b000,
        F3_OPFVV = 3'b001,
        F3_OPMVV = 3'b010,
        F3_OPIVI = 3'b011,
        F3_OPIVX = 3'b100,
        F3_OPFVF = 3'b101,
        F3_OPMVX = 3'b110,
        F3_OPCFG = 3'b111
    } v_func3_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISPATCH  = 3'd1,
        ST_EXEC_WAIT = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_RESP      = 3'd4
    } issue_state_e;

    typedef enum logic [1:0] {
        CLS_CFG     = 2'd0,
        CLS_ARITH   = 2'd1,
        CLS_MEM     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } inst_class_e;

    typedef struct packed {
        logic vl_sel;
        logic vtype_sel;
        logic lumop_sel;
        logic rs1rd_de;
        logic rs1_sel;
        logic vl_keep;
    } dec_sel_t;

    // Only OPIVV/OPIVI/OPIVX arithmetic is supported; the FP and MV groups
    // of OP-V are treated as illegal.
    function automatic inst_class_e classify_inst(input logic [6:0] opcode,
                                                  input logic [2:0] func3);
        inst_class_e cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_LOAD_FP, OP_STORE_FP: cls = CLS_MEM;
            OP_VEC: begin
                case (func3)
                    F3_OPCFG:                     cls = CLS_CFG;
                    F3_OPIVV, F3_OPIVI, F3_OPIVX: cls = CLS_ARITH;
                    default:                      cls = CLS_ILLEGAL;
                endcase
            end
            default: cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/vec_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// vec_issue_ctrl_if
// Scalar-core <-> vector issue controller handshake.
//   inst_valid  core offers an instruction (held until accepted)
//   inst_ready  controller idle and able to accept
//   vec_inst    instruction word
//   rs1_data    scalar rs1 operand
//   rs2_data    scalar rs2 operand
//   vec_done    one-cycle completion pulse
//   vec_err     qualifies vec_done: illegal instruction or timeout
// master = scalar core side, slave = issue controller side.
// -----------------------------------------------------------------------------
interface vec_issue_ctrl_if;
    import vec_issue_ctrl_pkg::*;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] vec_inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            vec_done;
    logic            vec_err;

    modport master (
        output inst_valid, vec_inst, rs1_data, rs2_data,
        input  inst_ready, vec_done, vec_err
    );

    modport slave (
        input  inst_valid, vec_inst, rs1_data, rs2_data,
        output inst_ready, vec_done, vec_err
    );

endinterface

// File: rtl/vec_issue_sel.sv
// -----------------------------------------------------------------------------
// vec_issue_sel
// Purely combinational decode of the held instruction into vec_decode selects.
//   inst      in   XLEN   held instruction word
//   sel       out  dec_sel_t  {vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, vl_keep}
//   inst_cls  out  inst_class_e  config / arith / mem / illegal
// -----------------------------------------------------------------------------
module vec_issue_sel
    import vec_issue_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output dec_sel_t        sel,
    output inst_class_e     inst_cls
);

    logic [6:0] opcode_s;
    logic [2:0] func3_s;
    logic [4:0] rs1_s;
    logic [4:0] rd_s;
    logic [1:0] mop_s;
    logic [1:0] cfg_kind_s;
    logic       rs1_nz_s;
    logic       unused_inst_bits_s;

    assign opcode_s   = inst[6:0];
    assign func3_s    = inst[14:12];
    assign rs1_s      = inst[19:15];
    assign rd_s       = inst[11:7];
    assign mop_s      = inst[27:26];
    assign cfg_kind_s = inst[31:30];
    assign rs1_nz_s   = (rs1_s != 5'd0);

    // vtype immediates / vs2 / vm fields are consumed by vec_decode, not here
    assign unused_inst_bits_s = ^{inst[29:28], inst[25:20]};

    // Select generation per instruction class
    always_comb begin
        sel      = 6'b000000;
        inst_cls = classify_inst(opcode_s, func3_s);
        case (inst_cls)
            CLS_CFG: begin
                if (cfg_kind_s == 2'b11) begin
                    // vsetivli: AVL is the uimm in the rs1 field
                    sel.vl_sel    = 1'b1;
                    sel.vtype_sel = 1'b1;
                    sel.rs1rd_de  = 1'b1;
                end else begin
                    // vsetvli ([31]=0) takes vtype from the immediate,
                    // vsetvl ([31:30]=10) takes it from rs2
                    sel.vtype_sel = ~inst[31];
                    sel.rs1rd_de  = rs1_nz_s;
                    sel.vl_keep   = (~rs1_nz_s) & (rd_s == 5'd0);
                end
            end
            CLS_ARITH: begin
                sel.rs1rd_de = 1'b1;
                sel.rs1_sel  = 1'b1;
            end
            CLS_MEM: begin
                // rs1 is the raw base address; non-unit mops pass rs2 as stride
                sel.rs1rd_de  = 1'b1;
                sel.rs1_sel   = 1'b1;
                sel.lumop_sel = (mop_s == MOP_UNIT);
            end
            default: begin
                sel = 6'b000000;
            end
        endcase
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vec_issue_ctrl
// Issue controller between the scalar core and the vector decode stage.
// One instruction in flight: accepted in IDLE, held for vec_decode, then
// CSR write (vset*), exec start or mem start, wait for done, respond.
// A watchdog turns a hung unit into an error response.
//   clk, reset        clock and synchronous active-high reset
//   core              slave side of the scalar-core handshake
//   inst_q/rs1_q/rs2_q held instruction and operands -> vec_decode
//   vl_sel..vl_keep   decode selects (0 while idle)
//   csr_wr_en         1-cycle CSR load pulse for vset*
//   exec_start/done   arithmetic unit start pulse / completion
//   mem_start/done    load/store unit start pulse / completion
// -----------------------------------------------------------------------------
module vec_issue_ctrl
    import vec_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    vec_issue_ctrl_if.slave core,
    output logic [XLEN-1:0] inst_q,
    output logic [XLEN-1:0] rs1_q,
    output logic [XLEN-1:0] rs2_q,
    output logic            vl_sel,
    output logic            vtype_sel,
    output logic            lumop_sel,
    output logic            rs1rd_de,
    output logic            rs1_sel,
    output logic            vl_keep,
    output logic            csr_wr_en,
    output logic            exec_start,
    input  logic            exec_done,
    output logic            mem_start,
    input  logic            mem_done
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    issue_state_e    state_q, state_d;
    logic [XLEN-1:0] inst_d, rs1_d, rs2_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            inst_ready_q, inst_ready_d;
    logic            csr_wr_en_q, csr_wr_en_d;
    logic            exec_start_q, exec_start_d;
    logic            mem_start_q, mem_start_d;
    logic            vec_done_q, vec_done_d;
    logic            vec_err_q, vec_err_d;

    dec_sel_t        sel_s;
    inst_class_e     dec_cls_s;
    inst_class_e     in_cls_s;
    logic            busy_s;
    logic            wait_done_s;

    vec_issue_sel u_sel (
        .inst     (inst_q),
        .sel      (sel_s),
        .inst_cls (dec_cls_s)
    );

    // The start pulse must be high in the DISPATCH cycle itself, so the
    // incoming word is classified at accept time to set that flop.
    assign in_cls_s    = classify_inst(core.vec_inst[6:0], core.vec_inst[14:12]);
    assign busy_s      = (state_q != ST_IDLE);
    assign wait_done_s = (state_q == ST_EXEC_WAIT) ? exec_done : mem_done;

    assign vl_sel    = busy_s & sel_s.vl_sel;
    assign vtype_sel = busy_s & sel_s.vtype_sel;
    assign lumop_sel = busy_s & sel_s.lumop_sel;
    assign rs1rd_de  = busy_s & sel_s.rs1rd_de;
    assign rs1_sel   = busy_s & sel_s.rs1_sel;
    assign vl_keep   = busy_s & sel_s.vl_keep;

    assign core.inst_ready = inst_ready_q;
    assign core.vec_done   = vec_done_q;
    assign core.vec_err    = vec_err_q;
    assign csr_wr_en       = csr_wr_en_q;
    assign exec_start      = exec_start_q;
    assign mem_start       = mem_start_q;

    // Next state, hold registers, watchdog and next values of the output pulses
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        wd_d         = wd_q;
        csr_wr_en_d  = 1'b0;
        exec_start_d = 1'b0;
        mem_start_d  = 1'b0;
        vec_done_d   = 1'b0;
        vec_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core.inst_valid) begin
                    inst_d  = core.vec_inst;
                    rs1_d   = core.rs1_data;
                    rs2_d   = core.rs2_data;
                    state_d = ST_DISPATCH;
                    case (in_cls_s)
                        CLS_CFG:   csr_wr_en_d  = 1'b1;
                        CLS_ARITH: exec_start_d = 1'b1;
                        CLS_MEM:   mem_start_d  = 1'b1;
                        default:   csr_wr_en_d  = 1'b0;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                // done inputs are deliberately not looked at here
                case (dec_cls_s)
                    CLS_CFG: begin
                        state_d    = ST_RESP;
                        vec_done_d = 1'b1;
                    end
                    CLS_ARITH: begin
                        state_d = ST_EXEC_WAIT;
                        wd_d    = {WD_W{1'b0}};
                    end
                    CLS_MEM: begin
                        state_d = ST_MEM_WAIT;
                        wd_d    = {WD_W{1'b0}};
                    end
                    default: begin
                        state_d    = ST_RESP;
                        vec_done_d = 1'b1;
                        vec_err_d  = 1'b1;
                    end
                endcase
            end
            ST_EXEC_WAIT, ST_MEM_WAIT: begin
                // a done arriving in the expiry cycle still counts as success
                if (wait_done_s) begin
                    state_d    = ST_RESP;
                    vec_done_d = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    state_d    = ST_RESP;
                    vec_done_d = 1'b1;
                    vec_err_d  = 1'b1;
                end else begin
                    wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        inst_ready_d = (state_d == ST_IDLE);
    end

    // State, hold registers, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            inst_q       <= {XLEN{1'b0}};
            rs1_q        <= {XLEN{1'b0}};
            rs2_q        <= {XLEN{1'b0}};
            wd_q         <= {WD_W{1'b0}};
            inst_ready_q <= 1'b1;
            csr_wr_en_q  <= 1'b0;
            exec_start_q <= 1'b0;
            mem_start_q  <= 1'b0;
            vec_done_q   <= 1'b0;
            vec_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            wd_q         <= wd_d;
            inst_ready_q <= inst_ready_d;
            csr_wr_en_q  <= csr_wr_en_d;
            exec_start_q <= exec_start_d;
            mem_start_q  <= mem_start_d;
            vec_done_q   <= vec_done_d;
            vec_err_q    <= vec_err_d;
        end
    end

endmodule
